// File: rtl/mem_arb_pkg.sv
// Shared types for the CPU/SDRAM arbiter: FSM states, port ids, opcodes and bus widths.
// Optional round-robin arbitration is enabled by defining MEM_ARB_RR_EN.
package mem_arb_pkg;

   localparam int ADDR_W = 26;
   localparam int DATA_W = 128;

   typedef enum logic [1:0] {
      ST_IDLE    = 2'd0,
      ST_ISSUE   = 2'd1,
      ST_WAIT_RD = 2'd2
   } state_t;

   typedef enum logic {
      PORT_I = 1'b0,
      PORT_D = 1'b1
   } port_t;

   typedef enum logic {
      OP_RD = 1'b0,
      OP_WR = 1'b1
   } op_t;

endpackage

// File: rtl/mem_arbiter_if.sv
// Bundles the CPU instruction/data ports and the Avalon-MM master signals of the arbiter.
// The master modport is the arbiter's view; the slave modport is the CPU + memory side.
interface mem_arbiter_if;
   import mem_arb_pkg::*;

   logic              i_read;
   logic [ADDR_W-1:0] i_addr;
   logic [DATA_W-1:0] i_rdata;
   logic              i_ready;

   logic              d_read;
   logic              d_write;
   logic [ADDR_W-1:0] d_addr;
   logic [DATA_W-1:0] d_wdata;
   logic [DATA_W-1:0] d_rdata;
   logic              d_ready;

   logic              avl_wait;
   logic              avl_readdatavalid;
   logic [DATA_W-1:0] avl_readdata;
   logic              avl_read;
   logic              avl_write;
   logic [ADDR_W-1:0] avl_address;
   logic [DATA_W-1:0] avl_writedata;

   modport master (
      input  i_read, i_addr, d_read, d_write, d_addr, d_wdata,
      input  avl_wait, avl_readdatavalid, avl_readdata,
      output i_rdata, i_ready, d_rdata, d_ready,
      output avl_read, avl_write, avl_address, avl_writedata
   );

   modport slave (
      output i_read, i_addr, d_read, d_write, d_addr, d_wdata,
      output avl_wait, avl_readdatavalid, avl_readdata,
      input  i_rdata, i_ready, d_rdata, d_ready,
      input  avl_read, avl_write, avl_address, avl_writedata
   );

endinterface

// File: rtl/mem_arb_grant.sv
// Two-way grant selection between the instruction and data ports.
// MEM_ARB_RR_EN selects round-robin; otherwise D has fixed priority over I.
module mem_arb_grant
   import mem_arb_pkg::*;
(
   input  logic [1:0] req_i,
   input  port_t      last_i,
   input  logic       en_i,
   output logic [1:0] gnt_o
);

`ifdef MEM_ARB_RR_EN
   // On a tie, the port that lost the previous grant wins this one
   always_comb begin
      gnt_o = 2'b00;
      if (en_i) begin
         if (req_i[PORT_I] && req_i[PORT_D]) begin
            if (last_i == PORT_D) gnt_o[PORT_I] = 1'b1;
            else                  gnt_o[PORT_D] = 1'b1;
         end else begin
            gnt_o = req_i;
         end
      end
   end
`else
   logic unusedLast;
   assign unusedLast = last_i;

   // The data port always wins a tie; instruction fetch waits for it
   always_comb begin
      gnt_o = 2'b00;
      if (en_i) begin
         if (req_i[PORT_D])      gnt_o[PORT_D] = 1'b1;
         else if (req_i[PORT_I]) gnt_o[PORT_I] = 1'b1;
      end
   end
`endif

endmodule

// File: rtl/mem_arbiter.sv
// Shares one Avalon-MM SDRAM master between CPU instruction and data ports, one transaction at a time.
// Arbitration policy is round-robin when MEM_ARB_RR_EN is defined, D-over-I fixed priority otherwise.
module mem_arbiter
   import mem_arb_pkg::*;
(
   input logic           iCLK,
   input logic           iRST,
   mem_arbiter_if.master bus
);

   state_t            state_q, state_d;
   port_t             port_q, port_d;
   port_t             last_q, last_d;
   op_t               op_q, op_d;
   logic              avlRead_q, avlRead_d;
   logic              avlWrite_q, avlWrite_d;
   logic [ADDR_W-1:0] avlAddr_q, avlAddr_d;
   logic [DATA_W-1:0] avlWdata_q, avlWdata_d;
   logic [DATA_W-1:0] iRdata_q, iRdata_d;
   logic [DATA_W-1:0] dRdata_q, dRdata_d;
   logic              iReady_q, iReady_d;
   logic              dReady_q, dReady_d;

   logic [1:0]        req;
   logic [1:0]        gnt;

   // A port whose done pulse is high this cycle is still holding its old request, so mask it
   assign req[PORT_I] = bus.i_read & ~iReady_q;
   assign req[PORT_D] = (bus.d_read | bus.d_write) & ~dReady_q;

   mem_arb_grant uGrant (
      .req_i  (req),
      .last_i (last_q),
      .en_i   (state_q == ST_IDLE),
      .gnt_o  (gnt)
   );

   always_ff @(posedge iCLK or posedge iRST) begin
      if (iRST) state_q <= ST_IDLE;
      else      state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_IDLE:    if (|gnt) state_d = ST_ISSUE;
         ST_ISSUE:   if (!bus.avl_wait) state_d = (op_q == OP_WR) ? ST_IDLE : ST_WAIT_RD;
         ST_WAIT_RD: if (bus.avl_readdatavalid) state_d = ST_IDLE;
         default:    state_d = ST_IDLE;
      endcase
   end

   // A simultaneous read and write on D is treated as a write
   always_comb begin
      port_d     = port_q;
      last_d     = last_q;
      op_d       = op_q;
      avlRead_d  = avlRead_q;
      avlWrite_d = avlWrite_q;
      avlAddr_d  = avlAddr_q;
      avlWdata_d = avlWdata_q;
      iRdata_d   = iRdata_q;
      dRdata_d   = dRdata_q;
      iReady_d   = 1'b0;
      dReady_d   = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (gnt[PORT_D]) begin
               port_d     = PORT_D;
               last_d     = PORT_D;
               op_d       = bus.d_write ? OP_WR : OP_RD;
               avlAddr_d  = bus.d_addr;
               avlWdata_d = bus.d_wdata;
               avlRead_d  = ~bus.d_write;
               avlWrite_d = bus.d_write;
            end else if (gnt[PORT_I]) begin
               port_d     = PORT_I;
               last_d     = PORT_I;
               op_d       = OP_RD;
               avlAddr_d  = bus.i_addr;
               avlRead_d  = 1'b1;
               avlWrite_d = 1'b0;
            end
         end
         ST_ISSUE: begin
            if (!bus.avl_wait) begin
               avlRead_d  = 1'b0;
               avlWrite_d = 1'b0;
               if (op_q == OP_WR) dReady_d = 1'b1;
            end
         end
         ST_WAIT_RD: begin
            if (bus.avl_readdatavalid) begin
               if (port_q == PORT_D) begin
                  dRdata_d = bus.avl_readdata;
                  dReady_d = 1'b1;
               end else begin
                  iRdata_d = bus.avl_readdata;
                  iReady_d = 1'b1;
               end
            end
         end
         default: ;
      endcase
   end

   always_ff @(posedge iCLK or posedge iRST) begin
      if (iRST) begin
         port_q     <= PORT_I;
         last_q     <= PORT_D;
         op_q       <= OP_RD;
         avlRead_q  <= 1'b0;
         avlWrite_q <= 1'b0;
         avlAddr_q  <= '0;
         avlWdata_q <= '0;
         iRdata_q   <= '0;
         dRdata_q   <= '0;
         iReady_q   <= 1'b0;
         dReady_q   <= 1'b0;
      end else begin
         port_q     <= port_d;
         last_q     <= last_d;
         op_q       <= op_d;
         avlRead_q  <= avlRead_d;
         avlWrite_q <= avlWrite_d;
         avlAddr_q  <= avlAddr_d;
         avlWdata_q <= avlWdata_d;
         iRdata_q   <= iRdata_d;
         dRdata_q   <= dRdata_d;
         iReady_q   <= iReady_d;
         dReady_q   <= dReady_d;
      end
   end

   assign bus.avl_read      = avlRead_q;
   assign bus.avl_write     = avlWrite_q;
   assign bus.avl_address   = avlAddr_q;
   assign bus.avl_writedata = avlWdata_q;
   assign bus.i_rdata       = iRdata_q;
   assign bus.i_ready       = iReady_q;
   assign bus.d_rdata       = dRdata_q;
   assign bus.d_ready       = dReady_q;

endmodule
